// File: rtl/loader_pkg.sv
// loader_pkg: shared states, widths and the capacity helper for the instruction memory loader.
package loader_pkg;

    typedef enum logic [2:0] {S_LEN, S_DATA, S_FLUSH, S_DONE, S_ERR} state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_MEM_DEPTH  = 1024;
    localparam int ADDR_W         = $clog2(DEF_MEM_DEPTH) + 2;

    // Words that fit between BASE_ADDR and the end of memory.
    function automatic logic [31:0] word_capacity(input int depth, input logic [31:0] base);
        return 32'(depth) - (base >> 2);
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: packs accepted bytes little-endian into 32-bit words.
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt;
    logic [23:0] sr;

    // The 4th byte is used directly, so the word is ready on its own sampling edge.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt <= '0;
            sr  <= '0;
        end else if (valid_i) begin
            cnt <= cnt + 2'd1;
            sr  <= {byte_i, sr[23:8]};
        end
    end

    assign word_o       = {byte_i, sr};
    assign word_valid_o = valid_i && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writes a length-prefixed byte stream into instruction memory and
// holds the core in reset until the image is committed.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cpu_rst_o
);

    localparam logic [31:0] CAP = word_capacity(MEM_DEPTH, BASE_ADDR);

    state_t              state, state_n;
    logic [31:0]         word, waddr;
    logic [ADDR_W-1:0]   remaining;
    logic                accept, word_valid, hdr, wr;

    assign accept = rx_valid_i && (state == S_LEN || state == S_DATA);
    assign hdr    = word_valid && state == S_LEN;
    assign wr     = word_valid && state == S_DATA;

    byte_word_assembler u_asm (
        .clk_i        (clk_i),
        .clr_i        (rst_i),
        .byte_i       (rx_data_i),
        .valid_i      (accept),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_LEN;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (hdr)
            state_n = (word == 32'd0) ? S_DONE : (word > CAP) ? S_ERR : S_DATA;
        else if (wr && remaining == ADDR_W'(1))
            state_n = S_FLUSH;
        else if (state == S_FLUSH)
            state_n = S_DONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= BASE_ADDR;
            mem_wdata_o <= '0;
            waddr       <= BASE_ADDR;
            remaining   <= '0;
        end else begin
            mem_we_o <= wr;
            if (hdr) begin
                remaining <= ADDR_W'(word);
                waddr     <= BASE_ADDR;
            end
            if (wr) begin
                mem_addr_o  <= waddr;
                mem_wdata_o <= word;
                waddr       <= waddr + 32'(BYTES_PER_WORD);
                remaining   <= remaining - ADDR_W'(1);
            end
        end
    end

    assign busy_o    = state == S_LEN || state == S_DATA || state == S_FLUSH;
    assign done_o    = state == S_DONE;
    assign error_o   = state == S_ERR;
    assign cpu_rst_o = !done_o;

endmodule
